// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU select codes and driver FSM states
// Contents:
//   ALU_N, ALU_M : default operand and result widths of the ALU operand interface
//   alu_sel_t    : 3-bit ALU select
//   SEL_*        : select codes for the eight ALU operations
//   drv_state_e  : command driver FSM states
package alu_pkg;

    localparam int ALU_N = 8;
    localparam int ALU_M = 16;

    typedef logic [2:0] alu_sel_t;

    localparam alu_sel_t SEL_ADD = 3'b000;  // A + B, carry kept in the wide result
    localparam alu_sel_t SEL_SUM = 3'b001;  // A + B modulo 2^N
    localparam alu_sel_t SEL_SUB = 3'b010;  // A - B at result width
    localparam alu_sel_t SEL_MUL = 3'b011;  // A * B
    localparam alu_sel_t SEL_AND = 3'b100;
    localparam alu_sel_t SEL_OR  = 3'b101;
    localparam alu_sel_t SEL_XOR = 3'b110;
    localparam alu_sel_t SEL_SHL = 3'b111;  // A << B[2:0]

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } drv_state_e;

endpackage

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - synchronous response FIFO
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write din when push and not full
//   pop, dout  : dout is the head entry; pop discards it when not empty
//   count      : number of stored entries (0..DEPTH)
//   full/empty : status flags
module alu_rsp_fifo #(
    parameter  int WIDTH = 19,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the
    // index bits are equal.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only observed after it is written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - clocked command front end for the combinational ALU
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_a/b/sel : operation command port
//   alu_a, alu_b, alu_sel        : registered operands driven into the ALU
//   alu_out                      : ALU result, sampled after SETTLE cycles
//   rsp_valid/ready, rsp_data/sel: result port, head of the response FIFO
//   op_count                     : results pushed, wrapping
//   busy                         : operation in flight or results queued
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int N         = ALU_N,
    parameter int M         = ALU_M,
    parameter int SETTLE    = 1,
    parameter int RSP_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_a,
    input  logic [N-1:0]     cmd_b,
    input  logic [2:0]       cmd_sel,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [2:0]       alu_sel,
    input  logic [M-1:0]     alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [M-1:0]     rsp_data,
    output logic [2:0]       rsp_sel,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);

    localparam int AW = $clog2(RSP_DEPTH);
    localparam int FW = M + 3;

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("alu_cmd_driver: SETTLE must be in 1..15");
    end
    if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_cmd_driver: RSP_DEPTH must be a power of 2 and at least 2");
    end

    drv_state_e    state;
    logic [3:0]    settle_cnt;
    logic          push;
    logic          pop;
    logic          accept;
    logic [FW-1:0] fifo_dout;
    logic [AW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    // Sampling happens on the last WAIT cycle; alu_out reaches outputs only
    // through the FIFO storage, so there is no combinational path.
    assign push   = (state == WAIT) && (settle_cnt == 4'd0);
    assign pop    = rsp_ready && !fifo_empty;
    // A pop on the same edge frees the slot the accepted command will need.
    assign cmd_ready = (state == IDLE) && (!fifo_full || rsp_ready);
    assign accept    = cmd_valid && cmd_ready;

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_dout[FW-1:3];
    assign rsp_sel   = fifo_dout[2:0];
    assign busy      = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            settle_cnt <= 4'd0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_b;
                        alu_sel    <= cmd_sel;
                        settle_cnt <= 4'(SETTLE - 1);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        op_count <= op_count + CNT_W'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    alu_rsp_fifo #(
        .WIDTH (FW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({alu_out, alu_sel}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - scoreboard bench for alu_cmd_driver with a behavioural ALU
module tb_alu_cmd_driver;
    import alu_pkg::*;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // dut_a: SETTLE=1, 4-bit counter. dut_b: SETTLE=3, default counter.
    logic        rst_n_a, cmd_valid_a, cmd_ready_a, rsp_valid_a, rsp_ready_a, busy_a;
    logic [7:0]  cmd_a_a, cmd_b_a, alu_a_a, alu_b_a;
    alu_sel_t    cmd_sel_a, alu_sel_a, rsp_sel_a;
    logic [15:0] alu_out_a, rsp_data_a;
    logic [3:0]  op_count_a;

    logic        rst_n_b, cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b, busy_b;
    logic [7:0]  cmd_a_b, cmd_b_b, alu_a_b, alu_b_b;
    alu_sel_t    cmd_sel_b, alu_sel_b, rsp_sel_b;
    logic [15:0] alu_out_b, rsp_data_b;
    logic [15:0] op_count_b;

    logic [18:0] exp_a [$];
    logic [18:0] exp_b [$];

    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input alu_sel_t s);
        case (s)
            SEL_ADD: return 16'(a) + 16'(b);
            SEL_SUM: return {8'h00, 8'(a + b)};
            SEL_SUB: return 16'(a) - 16'(b);
            SEL_MUL: return 16'(a) * 16'(b);
            SEL_AND: return {8'h00, a & b};
            SEL_OR:  return {8'h00, a | b};
            SEL_XOR: return {8'h00, a ^ b};
            default: return 16'(a) << b[2:0];
        endcase
    endfunction

    always_comb alu_out_a = alu_model(alu_a_a, alu_b_a, alu_sel_a);
    always_comb alu_out_b = alu_model(alu_a_b, alu_b_b, alu_sel_b);

    alu_cmd_driver #(.SETTLE(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_a(cmd_a_a), .cmd_b(cmd_b_a), .cmd_sel(cmd_sel_a),
        .alu_a(alu_a_a), .alu_b(alu_b_a), .alu_sel(alu_sel_a), .alu_out(alu_out_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_data(rsp_data_a),
        .rsp_sel(rsp_sel_a), .op_count(op_count_a), .busy(busy_a)
    );

    alu_cmd_driver #(.SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_a(cmd_a_b), .cmd_b(cmd_b_b), .cmd_sel(cmd_sel_b),
        .alu_a(alu_a_b), .alu_b(alu_b_b), .alu_sel(alu_sel_b), .alu_out(alu_out_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b),
        .rsp_sel(rsp_sel_b), .op_count(op_count_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitors sample just before each rising edge, when inputs and outputs
    // hold the values that edge will act on. Every valid cycle is compared
    // against the queue head, which also proves stability while stalled.
    initial forever begin
        @(negedge clk);
        #4;
        if (rsp_valid_a) begin
            if (exp_a.size() == 0) begin
                check("rsp_a_unexpected", 32'(rsp_valid_a), 32'd0);
            end else begin
                check("rsp_a", 32'({rsp_data_a, rsp_sel_a}), 32'(exp_a[0]));
                if (rsp_ready_a) void'(exp_a.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #4;
        if (rsp_valid_b) begin
            if (exp_b.size() == 0) begin
                check("rsp_b_unexpected", 32'(rsp_valid_b), 32'd0);
            end else begin
                check("rsp_b", 32'({rsp_data_b, rsp_sel_b}), 32'(exp_b[0]));
                if (rsp_ready_b) void'(exp_b.pop_front());
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_a(input logic [7:0] a, input logic [7:0] b, input alu_sel_t s,
                          input logic [15:0] rsp);
        int n = 0;
        cmd_valid_a = 1'b1; cmd_a_a = a; cmd_b_a = b; cmd_sel_a = s;
        while (!cmd_ready_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("send_a_timeout", 32'(n), 32'd0);
        end else begin
            exp_a.push_back({rsp, s});
            @(negedge clk);
        end
        cmd_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] a, input logic [7:0] b, input alu_sel_t s,
                          input logic [15:0] rsp, input bit want);
        int n = 0;
        cmd_valid_b = 1'b1; cmd_a_b = a; cmd_b_b = b; cmd_sel_b = s;
        while (!cmd_ready_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("send_b_timeout", 32'(n), 32'd0);
        end else begin
            if (want) exp_b.push_back({rsp, s});
            @(negedge clk);
        end
        cmd_valid_b = 1'b0;
    endtask

    task automatic drain(input bit which_b);
        int n = 0;
        while ((which_b ? exp_b.size() : exp_a.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(which_b ? "drain_b" : "drain_a",
              32'(which_b ? exp_b.size() : exp_a.size()), 32'd0);
    endtask

    logic [7:0]  tv_a   [8] = '{8'hFF, 8'hFF, 8'h10, 8'h12, 8'hF0, 8'hA0, 8'hFF, 8'h81};
    logic [7:0]  tv_b   [8] = '{8'h01, 8'h01, 8'h03, 8'h10, 8'h3C, 8'h05, 8'h0F, 8'h03};
    alu_sel_t    tv_s   [8] = '{SEL_ADD, SEL_SUM, SEL_SUB, SEL_MUL,
                                SEL_AND, SEL_OR, SEL_XOR, SEL_SHL};
    logic [15:0] tv_exp [8] = '{16'h0100, 16'h0000, 16'h000D, 16'h0120,
                                16'h0030, 16'h00A5, 16'h00F0, 16'h0408};

    initial begin
        rst_n_a = 1'b0; cmd_valid_a = 1'b0; cmd_a_a = '0; cmd_b_a = '0; cmd_sel_a = '0;
        rsp_ready_a = 1'b1;
        rst_n_b = 1'b0; cmd_valid_b = 1'b0; cmd_a_b = '0; cmd_b_b = '0; cmd_sel_b = '0;
        rsp_ready_b = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_rsp_valid_a", 32'(rsp_valid_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_alu_a", 32'({alu_a_a, alu_b_a, alu_sel_a}), 32'd0);
        check("rst_op_count_a", 32'(op_count_a), 32'd0);
        check("rst_op_count_b", 32'(op_count_b), 32'd0);
        check("rst_cmd_ready_b", 32'(cmd_ready_b), 32'd0 + 32'(1'b1));
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(negedge clk);

        // Single op, SETTLE=1
        send_a(8'h0A, 8'h02, SEL_ADD, 16'h000C);
        check("single_alu_a", 32'(alu_a_a), 32'h0A);
        check("single_alu_b", 32'(alu_b_a), 32'h02);
        check("single_valid_early", 32'(rsp_valid_a), 32'd0);
        check("single_ready_wait", 32'(cmd_ready_a), 32'd0);
        @(negedge clk);
        check("single_valid", 32'(rsp_valid_a), 32'd1);
        check("single_data", 32'(rsp_data_a), 32'h000C);
        check("single_op_count", 32'(op_count_a), 32'd1);
        drain(1'b0);
        check("single_hold_alu_a", 32'(alu_a_a), 32'h0A);

        // SETTLE=3
        send_b(8'h0B, 8'h03, SEL_SUM, 16'h000E, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("settle_ready_low", 32'(cmd_ready_b), 32'd0);
            check("settle_valid_low", 32'(rsp_valid_b), 32'd0);
            check("settle_busy", 32'(busy_b), 32'd1);
            @(negedge clk);
        end
        check("settle_valid", 32'(rsp_valid_b), 32'd1);
        check("settle_data", 32'(rsp_data_b), 32'h000E);
        drain(1'b1);

        // Backpressure: two results fill the FIFO, third command stalls
        rsp_ready_a = 1'b0;
        send_a(8'h01, 8'h01, SEL_ADD, 16'h0002);
        send_a(8'h02, 8'h02, SEL_ADD, 16'h0004);
        fork
            send_a(8'h03, 8'h03, SEL_ADD, 16'h0006);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_ready_low", 32'(cmd_ready_a), 32'd0);
                    check("bp_valid", 32'(rsp_valid_a), 32'd1);
                end
                rsp_ready_a = 1'b1;
            end
        join
        drain(1'b0);
        check("bp_op_count", 32'(op_count_a), 32'd4);

        // Counter wrap with CNT_W=4
        rst_n_a = 1'b0;
        #1;
        check("wrap_rst_count", 32'(op_count_a), 32'd0);
        @(negedge clk);
        rst_n_a = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) send_a(tv_a[i], tv_b[i], tv_s[i], tv_exp[i]);
        for (int i = 0; i < 9; i++) send_a(8'(i * 3), 8'h01, SEL_ADD, 16'(i * 3 + 1));
        @(negedge clk);
        check("wrap_op_count", 32'(op_count_a), 32'h1);
        drain(1'b0);

        // Async reset in the middle of WAIT
        send_b(8'h40, 8'h02, SEL_ADD, 16'h0042, 1'b0);
        rst_n_b = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid_b), 32'd0);
        check("mid_rst_busy", 32'(busy_b), 32'd0);
        check("mid_rst_alu", 32'({alu_a_b, alu_b_b, alu_sel_b}), 32'd0);
        check("mid_rst_count", 32'(op_count_b), 32'd0);
        @(negedge clk);
        rst_n_b = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_idle", 32'({busy_b, rsp_valid_b}), 32'd0);
        send_b(8'h20, 8'h05, SEL_SUB, 16'h001B, 1'b1);
        drain(1'b1);
        check("post_rst_count", 32'(op_count_b), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
